// File: rtl/i2s_pkg.sv
// Shared constants for the I2S receiver: default widths and the channel encoding
// carried by LRCK.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W      = 24;
    localparam int unsigned I2S_SYNC_STAGES = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } ch_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with a rising-edge strobe
// derived from one extra delayed copy of the synchronized level. STAGES must be >= 2.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int unsigned STAGES = I2S_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/i2s_1.sv
// I2S receiver: oversamples BCK/LRCK/SD, shifts in MSB-first words and publishes
// each completed word, left-aligned, on its channel output with a one-cycle strobe.
module i2s_1
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W      = I2S_DATA_W,
    parameter int unsigned SYNC_STAGES = I2S_SYNC_STAGES
) (
    input  logic              iSysClk,
    input  logic              iRst_n,
    input  logic              iBCK,
    input  logic              iLRCK,
    input  logic              iDataIn,
    output logic              oStrobeL,
    output logic              oStrobeR,
    output logic [DATA_W-1:0] oDataL,
    output logic [DATA_W-1:0] oDataR
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [DATA_W-1:0] MSB_ONE  = {1'b1, {(DATA_W-1){1'b0}}};

    logic bck_rise, lr_s, d_s;
    logic unused_bck_lvl, unused_lr_rise, unused_d_rise;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bck (
        .clk_i (iSysClk), .rst_ni(iRst_n), .d_i(iBCK),
        .q_o   (unused_bck_lvl), .rise_o(bck_rise)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lr (
        .clk_i (iSysClk), .rst_ni(iRst_n), .d_i(iLRCK),
        .q_o   (lr_s), .rise_o(unused_lr_rise)
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_d (
        .clk_i (iSysClk), .rst_ni(iRst_n), .d_i(iDataIn),
        .q_o   (d_s), .rise_o(unused_d_rise)
    );

    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ch_e               lr_prev_q, lr_prev_d;
    logic              aligned_q, aligned_d;
    logic [DATA_W-1:0] data_l_q, data_l_d, data_r_q, data_r_d;
    logic              stb_l_q, stb_l_d, stb_r_q, stb_r_d;

    always_comb begin
        word_d    = word_q;
        cnt_d     = cnt_q;
        lr_prev_d = lr_prev_q;
        aligned_d = aligned_q;
        data_l_d  = data_l_q;
        data_r_d  = data_r_q;
        stb_l_d   = 1'b0;
        stb_r_d   = 1'b0;
        if (bck_rise) begin
            // The bit sampled on the LRCK-transition rise is the LSB of the ending word,
            // so it is appended before the word is published and cleared.
            if (cnt_q < CNT_FULL) begin
                if (d_s) word_d = word_q | (MSB_ONE >> cnt_q);
                cnt_d = cnt_q + 1'b1;
            end
            if (ch_e'(lr_s) != lr_prev_q) begin
                if (aligned_q) begin
                    if (lr_prev_q == CH_LEFT) begin
                        data_l_d = word_d;
                        stb_l_d  = 1'b1;
                    end else begin
                        data_r_d = word_d;
                        stb_r_d  = 1'b1;
                    end
                end
                word_d    = '0;
                cnt_d     = '0;
                aligned_d = 1'b1;
                lr_prev_d = ch_e'(lr_s);
            end
        end
    end

    always_ff @(posedge iSysClk or negedge iRst_n) begin
        if (!iRst_n) begin
            word_q    <= '0;
            cnt_q     <= '0;
            lr_prev_q <= CH_LEFT;
            aligned_q <= 1'b0;
            data_l_q  <= '0;
            data_r_q  <= '0;
            stb_l_q   <= 1'b0;
            stb_r_q   <= 1'b0;
        end else begin
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            lr_prev_q <= lr_prev_d;
            aligned_q <= aligned_d;
            data_l_q  <= data_l_d;
            data_r_q  <= data_r_d;
            stb_l_q   <= stb_l_d;
            stb_r_q   <= stb_r_d;
        end
    end

    assign oStrobeL = stb_l_q;
    assign oStrobeR = stb_r_q;
    assign oDataL   = data_l_q;
    assign oDataR   = data_r_q;

endmodule

// File: tb/tb_i2s_1.sv
// Bench for i2s_1: drives I2S slots and predicts, per slot, which word must appear
// on which channel and at which iSysClk sample.
module tb_i2s_1;

    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst_n, bck, lrck, din;
    logic stbl, stbr;
    logic [DW-1:0] dl, dr;

    i2s_1 #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .iSysClk (clk),
        .iRst_n  (rst_n),
        .iBCK    (bck),
        .iLRCK   (lrck),
        .iDataIn (din),
        .oStrobeL(stbl),
        .oStrobeR(stbr),
        .oDataL  (dl),
        .oDataR  (dr)
    );

    always #2 clk = ~clk;

    typedef struct {
        logic          ch;
        logic [DW-1:0] val;
        longint        t;
    } exp_t;

    exp_t          expq[$];
    int            nchk = 0, npass = 0;
    int            cnt_l = 0, cnt_r = 0, base_r = 0, base_tot = 0;
    logic [DW-1:0] held_l = '0, held_r = '0;
    logic          m_lr = 1'b0, m_aligned = 1'b0, prev_lsb = 1'b0;
    logic [63:0]   prev_w = '0;
    int            prev_n = 16;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] align(input logic [63:0] w, input int n);
        logic [63:0] t;
        if (n >= DW) t = w >> (n - DW);
        else         t = w << (DW - n);
        return t[DW-1:0];
    endfunction

    always @(negedge clk) begin : cmp
        exp_t e;
        if (stbl || stbr) begin
            chk("strobe_excl", 64'(stbl & stbr), 64'd0);
            if (stbl) cnt_l++;
            if (stbr) cnt_r++;
            if (expq.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_strobe: got L=%0b R=%0b, required none", stbl, stbr);
            end else begin
                e = expq.pop_front();
                chk("strobe_ch", 64'(stbr), 64'(e.ch));
                chk("strobe_time", 64'($time), 64'(e.t));
                if (e.ch) held_r = e.val;
                else      held_l = e.val;
            end
        end
        chk("dataL", 64'(dl), 64'(held_l));
        chk("dataR", 64'(dr), 64'(held_r));
    end

    // hook: 1 = assert reset during this period, 2 = release reset
    task automatic bck_period(input logic lr, input logic d, input int hook);
        bck = 1'b0; lrck = lr; din = d;
        #4;
        if (hook == 1) begin
            rst_n = 1'b0;
            m_aligned = 1'b0; m_lr = 1'b0;
            held_l = '0; held_r = '0;
            expq.delete();
            base_r = cnt_r; base_tot = cnt_l + cnt_r;
            #1;
            chk("rst_mid_dataL", 64'(dl), 64'd0);
            chk("rst_mid_dataR", 64'(dr), 64'd0);
            chk("rst_mid_stb", 64'({stbl, stbr}), 64'd0);
            #5;
        end else begin
            if (hook == 2) rst_n = 1'b1;
            #6;
        end
        bck = 1'b1;
        #10;
    endtask

    task automatic send_slot(input logic ch, input int n, input logic [63:0] w,
                             input int hook_j = -1, input int hook = 0);
        exp_t   e;
        longint tr, r;
        for (int j = 0; j < n; j++) begin
            if (j == 0 && rst_n && ch != m_lr) begin
                if (m_aligned) begin
                    tr = $time + 10;
                    r  = (tr - 2) % 4;
                    e.ch  = m_lr;
                    e.val = align(prev_w, prev_n);
                    e.t   = tr + 4 - r + 10;
                    expq.push_back(e);
                end
                m_aligned = 1'b1;
                m_lr = ch;
            end
            bck_period(ch, (j == 0) ? prev_lsb : w[n-j], (j == hook_j) ? hook : 0);
        end
        prev_lsb = w[0];
        prev_w   = w;
        prev_n   = n;
    endtask

    initial begin
        logic [63:0] w;
        int          n;
        rst_n = 1'b0; bck = 1'b0; lrck = 1'b0; din = 1'b0;
        #11;
        chk("rst_dataL", 64'(dl), 64'd0);
        chk("rst_dataR", 64'(dr), 64'd0);
        chk("rst_stb", 64'({stbl, stbr}), 64'd0);
        #10;
        rst_n = 1'b1;

        send_slot(1'b0, 16, 64'hA72D);
        send_slot(1'b1, 16, 64'h2F6D);
        chk("align_dataL", 64'(dl), 64'd0);
        chk("align_dataR", 64'(dr), 64'd0);
        chk("align_nostb", 64'(cnt_l + cnt_r), 64'd0);

        send_slot(1'b0, 16, 64'hFFFE);
        send_slot(1'b1, 16, 64'h0001);
        chk("lit_R_2F6D", 64'(dr), 64'h2F6D00);
        chk("lit_L_FFFE", 64'(dl), 64'hFFFE00);
        chk("lit_cnt_R", 64'(cnt_r), 64'd1);
        chk("lit_cnt_L", 64'(cnt_l), 64'd1);

        send_slot(1'b0, 24, 64'h123456);
        chk("lit_R_0001", 64'(dr), 64'h000100);
        send_slot(1'b1, 24, 64'hABCDEF);
        send_slot(1'b0, 32, 64'h800001FF);
        chk("lit_L_24", 64'(dl), 64'h123456);
        chk("lit_R_24", 64'(dr), 64'hABCDEF);
        send_slot(1'b1, 16, 64'(16'($urandom)));
        chk("lit_L_32", 64'(dl), 64'h800001);

        send_slot(1'b0, 16, 64'(16'($urandom)));
        send_slot(1'b1, 16, 64'(16'($urandom)), 6, 1);
        send_slot(1'b0, 16, 64'(16'($urandom)), 4, 2);
        send_slot(1'b1, 16, 64'h5A5A);
        chk("rst_realign_nostb", 64'(cnt_l + cnt_r), 64'(base_tot));
        send_slot(1'b0, 16, 64'(16'($urandom)));
        send_slot(1'b1, 16, 64'(16'($urandom)));
        chk("lit_R_after_rst", 64'(dr), 64'h5A5A00);
        chk("cnt_R_after_rst", 64'(cnt_r - base_r), 64'd1);

        for (int i = 0; i < 20; i++) begin
            n = int'($urandom_range(8, 32));
            w = {$urandom(), $urandom()} & ((64'd1 << n) - 64'd1);
            send_slot(i[0], n, w);
        end
        send_slot(1'b0, 8, 64'(8'($urandom)));
        #60;
        chk("pending_strobes", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/i2s_1.md
# i2s_1

I2S serial-audio receiver in the `iSysClk` domain, sitting between the external audio serial port (BCK/LRCK/SD) and the parallel audio datapath. It oversamples `iBCK`, `iLRCK` and `iDataIn` with `iSysClk` and deserialises MSB-first I2S words with the standard one-BCK delay after each LRCK transition. It presents each completed word as a left-aligned 24-bit sample with a one-cycle strobe per channel.

## Interface
- `DATA_W`, default 24: output sample width; longer words are truncated, shorter words are zero-padded in the LSBs.
- `SYNC_STAGES`, default 2: synchronizer depth applied to `iBCK`, `iLRCK` and `iDataIn`.
- `iSysClk`  in  1  the single clock of the block; all state is clocked on its rising edge.
- `iRst_n`  in  1  asynchronous, active-low reset.
- `iBCK`  in  1  I2S bit clock, treated as data; frequency ≤ `iSysClk`/4, with each phase ≥ 2 `iSysClk` periods.
- `iLRCK`  in  1  word select, changes on BCK falling edges; 0 = left, 1 = right.
- `iDataIn`  in  1  serial data, changes on BCK falling edges, MSB first.
- `oStrobeL`  out  1  one-cycle pulse, `oDataL` updated.
- `oStrobeR`  out  1  one-cycle pulse, `oDataR` updated.
- `oDataL`  out  DATA_W  last complete left sample, MSB-aligned.
- `oDataR`  out  DATA_W  last complete right sample, MSB-aligned.

## Operation
- Reset values:
  - All outputs are 0.
  - Shift word, bit count, previous-LRCK register and synchronizers are 0.
  - The `aligned` flag is 0.
- Synchronization and sampling:
  - `iBCK`, `iLRCK` and `iDataIn` each pass through identical `SYNC_STAGES`-deep synchronizers.
  - A BCK rising edge is detected as synced BCK = 1 while the extra delayed copy = 0.
  - `lr` and `d` are sampled only on a detected BCK rise.
- On each BCK rise, append first:
  - If count < DATA_W, then word[DATA_W-1-count] ← d and count++.
  - Bits beyond DATA_W are discarded.
- On a BCK rise where `lr` ≠ `lr_prev` (LRCK transition):
  - The bit sampled at this rise is the LSB slot of the ending word. It is appended first, per the rule above.
  - If `aligned` = 1, the ending word is copied to `oDataL` when `lr_prev` = 0, or to `oDataR` when `lr_prev` = 1. The matching strobe pulses.
  - After that, the word register is cleared and count is cleared to 0.
  - `aligned` is then set to 1 and `lr_prev` is updated to `lr`.
- The first LRCK transition after reset only aligns the receiver: no strobe is produced and no output changes.
- `oDataL`/`oDataR` hold their value until the next completed word of the same channel.
- At most one strobe is high in any cycle; `oStrobeL` and `oStrobeR` are never high together.
- A word with zero bits is output as 0.

## Timing
- Let n be the first `iSysClk` edge at which the first synchronizer stage captures BCK = 1, with `SYNC_STAGES` = 2.
  - The edge-detect is true in the cycle after edge n+1.
  - Output register and strobe update at edge n+2.
  - The strobe is high for exactly one `iSysClk` cycle.
- Data and LRCK share the BCK synchronizer latency, so the sampled values are those present at the BCK rising edge, within ±1 `iSysClk`.
- Reset asserted mid-word:
  - All state clears immediately, asynchronously.
  - After release, the partial frame is discarded via the `aligned` rule.
- A BCK frequency above `iSysClk`/4 is out of spec; behaviour in that case is undefined.

## Structure
- Shared package `i2s_pkg` holds:
  - `I2S_DATA_W` = 24 and `I2S_SYNC_STAGES` = 2.
  - The channel encoding constants: `CH_LEFT` = 0, `CH_RIGHT` = 1.
- Sub-module `i2s_sync_edge` contains the N-stage synchronizer plus the rising-edge detector for BCK. It is instantiated for the three inputs; only the BCK instance uses the edge output.
- The top level holds the shift word, bit counter, `lr_prev`, the `aligned` flag and the output registers.

## Test plan
Unless stated otherwise: `iSysClk` period 4, BCK period 20, 16 BCKs per channel slot.

- Reset, then a first left word 0xA72D → no strobes; `oDataL` = `oDataR` = 0 (alignment frame).
- Right word 0x2F6D, then left 0xFFFE → `oStrobeR` once with `oDataR` = 0x2F6D00, then `oStrobeL` once with `oDataL` = 0xFFFE00.
- Right word 0x0001, then an LRCK fall → `oDataR` = 0x000100. Strobe occurs 2 `iSysClk` edges after the first synchronizer captures the BCK rise following the LRCK edge.
- 24-bit slots carrying L = 0x123456, R = 0xABCDEF → `oDataL` = 0x123456, `oDataR` = 0xABCDEF, each with exactly one strobe pulse.
- 32-bit slots whose top 24 bits are 0x800001, followed by 8 ones → `oDataL` = 0x800001; the extra bits are dropped.
- Assert `iRst_n` low mid-right-word → outputs go to 0 immediately. After release, the next LRCK transition yields no strobe, and the following word is received correctly.
